// File: rtl/reset_sequencer.sv
// reset_sequencer: power-up / warm reset sequencing for the Propeller core.
// Holds the PLL in reset, waits for a synchronised lock, then holds the core
// for a settle period before releasing it. Software reboots, lock loss and
// (optionally) a watchdog re-enter the sequence; the last cause is recorded.
// Optional feature: define WATCHDOG_EN to build the watchdog counter.
module reset_sequencer #(
    parameter logic [31:0] DELAY_CYCLES    = 32'd8_000_000,
    parameter logic [31:0] PLL_HOLD_CYCLES = 32'd16,
    parameter logic [31:0] LOCK_TIMEOUT    = 32'd1_600_000,
    parameter logic [31:0] WDT_CYCLES      = 32'd160_000_000
) (
    input  logic       clock_160,
    input  logic       resn,
    input  logic       pll_lock,
    input  logic       sw_res_req,
    input  logic       wdt_en,
    input  logic       wdt_kick,
    output logic       res_pll,
    output logic       res,
    output logic [1:0] res_cause,
    output logic       busy
);

    // Zero-length parameters behave as one cycle, so loads never underflow.
    localparam logic [31:0] HOLD_LOAD  = (PLL_HOLD_CYCLES == 32'd0) ? 32'd0 : PLL_HOLD_CYCLES - 32'd1;
    localparam logic [31:0] LOCK_LOAD  = (LOCK_TIMEOUT == 32'd0)    ? 32'd0 : LOCK_TIMEOUT - 32'd1;
    localparam logic [31:0] DELAY_LOAD = (DELAY_CYCLES == 32'd0)    ? 32'd0 : DELAY_CYCLES - 32'd1;

    localparam logic [1:0] CAUSE_SW   = 2'd1;
    localparam logic [1:0] CAUSE_WDT  = 2'd2;
    localparam logic [1:0] CAUSE_LOCK = 2'd3;

    typedef enum logic [1:0] {
        PLL_HOLD  = 2'd0,
        LOCK_WAIT = 2'd1,
        SETTLE    = 2'd2,
        RUN       = 2'd3
    } state_t;

    state_t      state_reg, state_next;
    logic [31:0] cnt_reg, cnt_next;
    logic [1:0]  cause_next;
    logic        lock_meta, lock_s;
    logic        wdt_expire;

    // Two-flop lock synchroniser; cleared while the PLL is held in reset so a
    // lock level left over from before the PLL reset is never trusted.
    always_ff @(posedge clock_160 or negedge resn) begin
        if (!resn) begin
            lock_meta <= 1'b0;
            lock_s    <= 1'b0;
        end else if (res_pll) begin
            lock_meta <= 1'b0;
            lock_s    <= 1'b0;
        end else begin
            lock_meta <= pll_lock;
            lock_s    <= lock_meta;
        end
    end

`ifdef WATCHDOG_EN
    localparam logic [31:0] WDT_LOAD = (WDT_CYCLES == 32'd0) ? 32'd0 : WDT_CYCLES - 32'd1;

    logic [31:0] wdt_cnt_reg, wdt_cnt_next;

    assign wdt_expire = (state_reg == RUN) && wdt_en && (wdt_cnt_reg == 32'd0);

    // Watchdog count: reloaded on RUN entry, on a kick or while disabled;
    // counts down in RUN and parks at zero rather than wrapping.
    always_comb begin
        wdt_cnt_next = wdt_cnt_reg;
        if (state_reg != RUN) begin
            if (state_next == RUN) begin
                wdt_cnt_next = WDT_LOAD;
            end
        end else if (!wdt_en || wdt_kick) begin
            wdt_cnt_next = WDT_LOAD;
        end else if (wdt_cnt_reg != 32'd0) begin
            wdt_cnt_next = wdt_cnt_reg - 32'd1;
        end
    end

    // Watchdog counter register.
    always_ff @(posedge clock_160 or negedge resn) begin
        if (!resn) begin
            wdt_cnt_reg <= WDT_LOAD;
        end else begin
            wdt_cnt_reg <= wdt_cnt_next;
        end
    end
`else
    logic unused_wdt;

    assign wdt_expire = 1'b0;
    assign unused_wdt = &{1'b0, wdt_en, wdt_kick, WDT_CYCLES};
`endif

    // Next state, shared down-counter reload and reset-cause update.
    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        cause_next = res_cause;
        case (state_reg)
            PLL_HOLD: begin
                if (cnt_reg == 32'd0) begin
                    state_next = LOCK_WAIT;
                    cnt_next   = LOCK_LOAD;
                end else begin
                    cnt_next = cnt_reg - 32'd1;
                end
            end
            LOCK_WAIT: begin
                if (lock_s) begin
                    state_next = SETTLE;
                    cnt_next   = DELAY_LOAD;
                end else if (cnt_reg == 32'd0) begin
                    state_next = PLL_HOLD;
                    cnt_next   = HOLD_LOAD;
                    cause_next = CAUSE_LOCK;
                end else begin
                    cnt_next = cnt_reg - 32'd1;
                end
            end
            SETTLE: begin
                if (!lock_s) begin
                    state_next = PLL_HOLD;
                    cnt_next   = HOLD_LOAD;
                    cause_next = CAUSE_LOCK;
                end else if (cnt_reg == 32'd0) begin
                    state_next = RUN;
                end else begin
                    cnt_next = cnt_reg - 32'd1;
                end
            end
            RUN: begin
                if (!lock_s) begin
                    state_next = PLL_HOLD;
                    cnt_next   = HOLD_LOAD;
                    cause_next = CAUSE_LOCK;
                end else if (wdt_expire) begin
                    state_next = SETTLE;
                    cnt_next   = DELAY_LOAD;
                    cause_next = CAUSE_WDT;
                end else if (sw_res_req) begin
                    state_next = SETTLE;
                    cnt_next   = DELAY_LOAD;
                    cause_next = CAUSE_SW;
                end
            end
            default: begin
                state_next = PLL_HOLD;
                cnt_next   = HOLD_LOAD;
            end
        endcase
    end

    // State, counter and registered outputs decoded from the next state.
    always_ff @(posedge clock_160 or negedge resn) begin
        if (!resn) begin
            state_reg <= PLL_HOLD;
            cnt_reg   <= HOLD_LOAD;
            res_pll   <= 1'b1;
            res       <= 1'b1;
            busy      <= 1'b1;
            res_cause <= 2'd0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            res_pll   <= (state_next == PLL_HOLD);
            res       <= (state_next != RUN);
            busy      <= (state_next != RUN);
            res_cause <= cause_next;
        end
    end

endmodule
